// File: rtl/pair_feeder.sv
// -----------------------------------------------------------------------------
// pair_feeder
//
// Feeder stage in front of the two-input buffer block. Single words arrive
// over a valid/ready handshake and go into a DEPTH-entry circular FIFO.
// Whenever two or more words are stored and hold is low, the two oldest words
// are popped together and presented as a registered pair on out0/out1, with a
// one-cycle pair_en strobe. flush clears all buffered words. dropped pulses
// when that flush threw data away.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   s_data   in   N-bit input word
//   s_valid  in   s_data is valid
//   s_ready  out  FIFO can take a word this cycle
//   hold     in   suppress pair emission
//   flush    in   synchronous clear of buffered words
//   out0     out  older word of the emitted pair
//   out1     out  newer word of the emitted pair
//   pair_en  out  one-cycle strobe, out0/out1 carry a new pair
//   count    out  number of stored words
//   dropped  out  one-cycle pulse, a flush discarded stored words
// -----------------------------------------------------------------------------
module pair_feeder #(
   parameter int N     = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N-1:0]             s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic                     hold,
   input  logic                     flush,
   output logic [N-1:0]             out0,
   output logic [N-1:0]             out1,
   output logic                     pair_en,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [N-1:0]    mem [DEPTH];

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [N-1:0]    out0_q, out0_d;
   logic [N-1:0]    out1_q, out1_d;
   logic            pair_en_q, pair_en_d;
   logic            dropped_q, dropped_d;

   logic            wr_en;
   logic            pop;
   logic [AW-1:0]   rd_ptr_p1;

   // rst is folded in so no handshake completes while reset is held
   assign s_ready   = rst && (count_q != FULL_CNT);
   assign wr_en     = s_valid && s_ready && !flush;
   assign pop       = (count_q >= CW'(2)) && !hold && !flush;
   // Natural wrap of the AW-bit pointer lets a pair straddle the array top
   assign rd_ptr_p1 = rd_ptr_q + AW'(1);

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      out0_d    = out0_q;
      out1_d    = out1_q;
      pair_en_d = 1'b0;
      dropped_d = 1'b0;
      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         dropped_d = (count_q != '0);
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            out0_d    = mem[rd_ptr_q];
            out1_d    = mem[rd_ptr_p1];
            rd_ptr_d  = rd_ptr_q + AW'(2);
            pair_en_d = 1'b1;
         end
         // The write and the pop both use the pre-edge count, so a full FIFO
         // refuses the write even when a pair leaves in the same cycle
         count_d = count_q + CW'(wr_en) - (pop ? CW'(2) : CW'(0));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         out0_q    <= '0;
         out1_q    <= '0;
         pair_en_q <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         out0_q    <= out0_d;
         out1_q    <= out1_d;
         pair_en_q <= pair_en_d;
         dropped_q <= dropped_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= s_data;
      end
   end

   assign out0    = out0_q;
   assign out1    = out1_q;
   assign pair_en = pair_en_q;
   assign count   = count_q;
   assign dropped = dropped_q;

endmodule

// File: tb/tb_pair_feeder.sv
// -----------------------------------------------------------------------------
// tb_pair_feeder
//
// Directed bench for pair_feeder (N=32, DEPTH=8). Stimulus pushes the pairs
// it expects into a queue; a monitor on the falling edge pops one entry each
// time pair_en is seen and compares it with out0/out1. Level checks on count,
// s_ready, dropped and pair_en timing are made from the stimulus process.
// -----------------------------------------------------------------------------
module tb_pair_feeder;

   logic          clk;
   logic          rst;
   logic [31:0]   s_data;
   logic          s_valid;
   logic          s_ready;
   logic          hold;
   logic          flush;
   logic [31:0]   out0;
   logic [31:0]   out1;
   logic          pair_en;
   logic [3:0]    count;
   logic          dropped;

   int            n_cmp;
   int            n_err;
   logic [63:0]   exp_q[$];

   pair_feeder #(.N(32), .DEPTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .hold    (hold),
      .flush   (flush),
      .out0    (out0),
      .out1    (out1),
      .pair_en (pair_en),
      .count   (count),
      .dropped (dropped)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Drive one cycle of inputs and return 1 time unit after the rising edge
   task automatic step(input logic v, input logic [31:0] d, input logic h, input logic f);
      s_valid = v;
      s_data  = d;
      hold    = h;
      flush   = f;
      @(posedge clk);
      #1;
   endtask

   task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
      exp_q.push_back({a, b});
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst && pair_en) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pair: got %0h,%0h required no pair", out0, out1);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("pair", {out0, out1}, e);
         end
      end
   end

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      hold    = 1'b0;
      flush   = 1'b0;

      // ---------------- reset state ----------------
      #2;
      chk("rst_count",   64'(count),   64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_pair_en", 64'(pair_en), 64'd0);
      chk("rst_out0",    64'(out0),    64'd0);
      #10;
      rst = 1'b1;
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("rel_s_ready", 64'(s_ready), 64'd1);

      // ---------------- basic pairing ----------------
      push_pair(32'h1, 32'h2);
      push_pair(32'h3, 32'h4);
      step(1'b1, 32'h1, 1'b0, 1'b0);
      step(1'b1, 32'h2, 1'b0, 1'b0);
      chk("basic_count2",  64'(count),   64'd2);
      chk("basic_no_pair", 64'(pair_en), 64'd0);
      step(1'b1, 32'h3, 1'b0, 1'b0);
      chk("basic_latency", 64'(pair_en), 64'd1);
      chk("basic_count1",  64'(count),   64'd1);
      step(1'b1, 32'h4, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("basic_count0",  64'(count),   64'd0);

      // ---------------- odd word ----------------
      push_pair(32'hA, 32'hB);
      push_pair(32'hC, 32'hD);
      step(1'b1, 32'hA, 1'b0, 1'b0);
      step(1'b1, 32'hB, 1'b0, 1'b0);
      step(1'b1, 32'hC, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("odd_count1",  64'(count),   64'd1);
      chk("odd_no_pair", 64'(pair_en), 64'd0);
      step(1'b1, 32'hD, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("odd_count0",  64'(count),   64'd0);

      // ---------------- hold and full ----------------
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 32'(i), 1'b1, 1'b0);
      end
      chk("full_count",   64'(count),   64'd8);
      chk("full_s_ready", 64'(s_ready), 64'd0);
      step(1'b1, 32'h8, 1'b1, 1'b0);
      chk("full_refused", 64'(count),   64'd8);
      push_pair(32'h0, 32'h1);
      push_pair(32'h2, 32'h3);
      push_pair(32'h4, 32'h5);
      push_pair(32'h6, 32'h7);
      push_pair(32'h8, 32'h9);
      // First release edge: pop but no write (full before the edge)
      step(1'b1, 32'h8, 1'b0, 1'b0);
      chk("rel_count6",  64'(count), 64'd6);
      // Word 8 accepted here while the second pair leaves
      step(1'b1, 32'h8, 1'b0, 1'b0);
      chk("rel_count5",  64'(count), 64'd5);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("rel_pair3",   64'(pair_en), 64'd1);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("rel_pair4",   64'(pair_en), 64'd1);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("rel_left1",   64'(count), 64'd1);
      step(1'b1, 32'h9, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("rel_count0",  64'(count), 64'd0);

      // ---------------- wrap-around ----------------
      for (int i = 0; i < 20; i += 2) begin
         push_pair(32'h100 + 32'(i), 32'h101 + 32'(i));
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 32'h100 + 32'(i), 1'((i / 3) % 2), 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 32'h0, 1'b0, 1'b0);
      end
      chk("wrap_count0", 64'(count), 64'd0);
      chk("wrap_sb",     64'(exp_q.size()), 64'd0);

      // ---------------- flush ----------------
      step(1'b1, 32'hE1, 1'b1, 1'b0);
      step(1'b1, 32'hE2, 1'b1, 1'b0);
      step(1'b1, 32'hE3, 1'b1, 1'b0);
      chk("fl_count3",   64'(count), 64'd3);
      step(1'b1, 32'hF0, 1'b0, 1'b1);
      chk("fl_dropped",  64'(dropped), 64'd1);
      chk("fl_count0",   64'(count),   64'd0);
      chk("fl_s_ready",  64'(s_ready), 64'd1);
      chk("fl_no_pair",  64'(pair_en), 64'd0);
      chk("fl_outs",     {out0, out1}, {32'h112, 32'h113});
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("fl_drop_1cy", 64'(dropped), 64'd0);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("fl_empty",    64'(dropped), 64'd0);
      // 0xF0 must be gone: next pair is built only from new words
      push_pair(32'h55, 32'h66);
      step(1'b1, 32'h55, 1'b0, 1'b0);
      step(1'b1, 32'h66, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("fl_after",    64'(count), 64'd0);

      // ---------------- asynchronous reset mid-stream ----------------
      step(1'b1, 32'h71, 1'b1, 1'b0);
      step(1'b1, 32'h72, 1'b1, 1'b0);
      step(1'b1, 32'h73, 1'b1, 1'b0);
      chk("ar_count3",   64'(count), 64'd3);
      s_valid = 1'b0;
      rst     = 1'b0;
      #2;
      chk("ar_count",    64'(count),   64'd0);
      chk("ar_pair_en",  64'(pair_en), 64'd0);
      chk("ar_outs",     {out0, out1}, 64'd0);
      chk("ar_s_ready",  64'(s_ready), 64'd0);
      #2;
      rst = 1'b1;
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("ar_release",  64'(s_ready), 64'd1);
      chk("ar_count0",   64'(count),   64'd0);

      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("final_sb",    64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
